// File: rtl/dpram_arb_pkg.sv
// Shared definitions for the dual-port RAM port arbiter.
// Provides default RAM geometry, address/data typedefs and a one-hot to
// index helper used when capturing which requester a read response belongs to.
package dpram_arb_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;
  // Widest requester vector onehot_to_idx can decode; NUM_REQ must not exceed it.
  localparam int unsigned MaxReq   = 32;

  typedef logic [DefAddrW-1:0] addr_t;
  typedef logic [DefDataW-1:0] data_t;

  // Index of the set bit of a one-hot (or zero) vector; 0 when no bit is set.
  function automatic int unsigned onehot_to_idx(input logic [MaxReq-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (onehot[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an external accept qualifier.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, pointer returns to 0
//   req_i      per-requester request
//   accept_i   when low the winner is not granted and the pointer holds
//   winner_o   one-hot/zero requester the search selected (independent of accept_i)
//   gnt_o      one-hot/zero grant = winner_o qualified by accept_i
// The search starts at the pointer; after a grant the pointer moves to the
// index just past the granted requester.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] winner_o,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    winner_o = '0;
    win_idx  = '0;
    cand     = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % N);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        winner_o[cand] = 1'b1;
        win_idx        = cand;
      end
    end
  end

  assign gnt_o = winner_o & {N{accept_i}};

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_o) begin
      ptr_d = (win_idx == IdxW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares the single write port and single read port of a synchronous
// dual-port RAM among NUM_REQ requesters.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   wr_req/wr_addr/wr_data   per-requester write channel (packed, requester i at slice i)
//   wr_gnt                   one-hot/zero write grant
//   rd_req/rd_addr           per-requester read channel (packed)
//   rd_gnt                   one-hot/zero read grant
//   rd_rvalid/rd_rdata       registered one-hot response valid, shared read data
//   ram_*                    drive of the RAM write/read ports; ram_data_out returns read data
// Write and read ports are arbitrated independently (round-robin each). A read
// whose address matches the same-cycle write is deferred one cycle so it
// returns the freshly written data.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        wr_gnt,
  input  logic [NUM_REQ-1:0]        rd_req,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_gnt,
  output logic [NUM_REQ-1:0]        rd_rvalid,
  output logic [DATA_W-1:0]         rd_rdata,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_wr_addr,
  output logic [DATA_W-1:0]         ram_data_in,
  output logic                      ram_rd_en,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic [DATA_W-1:0]         ram_data_out
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] wr_req_m, rd_req_m;
  logic [NUM_REQ-1:0] wr_win, rd_win;
  logic [ADDR_W-1:0]  wr_addr_w, rd_addr_w;
  logic [DATA_W-1:0]  wr_data_w;
  logic               hazard;

  logic               rvalid_q, rvalid_d;
  logic [IdxW-1:0]    rsp_idx_q, rsp_idx_d;

  // Requests are masked during reset so no grant or RAM enable can escape.
  assign wr_req_m = rst ? '0 : wr_req;
  assign rd_req_m = rst ? '0 : rd_req;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_wr_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (wr_req_m),
    .accept_i (1'b1),
    .winner_o (wr_win),
    .gnt_o    (wr_gnt)
  );

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rd_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (rd_req_m),
    .accept_i (!hazard),
    .winner_o (rd_win),
    .gnt_o    (rd_gnt)
  );

  always_comb begin
    wr_addr_w = '0;
    wr_data_w = '0;
    rd_addr_w = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_win[i]) begin
        wr_addr_w = wr_addr[i*ADDR_W +: ADDR_W];
        wr_data_w = wr_data[i*DATA_W +: DATA_W];
      end
      if (rd_win[i]) begin
        rd_addr_w = rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Compare against the read winner, not the grant, to avoid a loop through accept_i.
  assign hazard = (|wr_win) && (|rd_win) && (wr_addr_w == rd_addr_w);

  assign ram_wr_en   = |wr_gnt;
  assign ram_wr_addr = ram_wr_en ? wr_addr_w : '0;
  assign ram_data_in = ram_wr_en ? wr_data_w : '0;
  assign ram_rd_en   = |rd_gnt;
  assign ram_rd_addr = ram_rd_en ? rd_addr_w : '0;

  always_comb begin
    rvalid_d  = |rd_gnt;
    rsp_idx_d = rsp_idx_q;
    if (|rd_gnt) begin
      rsp_idx_d = IdxW'(onehot_to_idx(MaxReq'(rd_gnt)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      rsp_idx_q <= rsp_idx_d;
    end
  end

  // Gated by rst so a response pending when reset asserts is dropped immediately.
  always_comb begin
    rd_rvalid = '0;
    if (rvalid_q && !rst) begin
      rd_rvalid[rsp_idx_q] = 1'b1;
    end
  end

  assign rd_rdata = ram_data_out;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;

  localparam int NR = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_gnt;
  logic [1:0]  rd_req;
  logic [15:0] rd_addr;
  logic [1:0]  rd_gnt;
  logic [1:0]  rd_rvalid;
  logic [7:0]  rd_rdata;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_addr;
  logic [7:0]  ram_data_in;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_addr;
  logic [7:0]  ram_data_out;

  dpram_port_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (8),
    .DATA_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_rvalid    (rd_rvalid),
    .rd_rdata     (rd_rdata),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_out (ram_data_out)
  );

  // Behavioural 256x8 synchronous dual-port RAM.
  logic [7:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= ram_mem[ram_rd_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] wr_req;
    logic [7:0] wa0, wa1, wd0, wd1;
    logic [1:0] rd_req;
    logic [7:0] ra0, ra1;
    logic [1:0] e_wg, e_rg, e_rv;
    logic       chk_d;
    logic [7:0] e_d;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] wq, input logic [7:0] wa0,
                              input logic [7:0] wa1, input logic [7:0] wd0, input logic [7:0] wd1,
                              input logic [1:0] rq, input logic [7:0] ra0, input logic [7:0] ra1,
                              input logic [1:0] e_wg, input logic [1:0] e_rg,
                              input logic [1:0] e_rv, input logic chk, input logic [7:0] e_d);
    vec_t v;
    v.rst = r; v.wr_req = wq; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.rd_req = rq; v.ra0 = ra0; v.ra1 = ra1;
    v.e_wg = e_wg; v.e_rg = e_rg; v.e_rv = e_rv; v.chk_d = chk; v.e_d = e_d;
    return v;
  endfunction

  localparam int NV = 22;
  vec_t vecs [NV];

  // Soak state
  logic       wr_pend [2];
  logic       rd_pend [2];
  logic [7:0] wr_a [2];
  logic [7:0] wr_d [2];
  logic [7:0] rd_a [2];
  int         wr_wait [2];
  int         rd_wait [2];
  logic [7:0] ref_mem [256];
  bit         known [256];
  logic [1:0] exp_rv;
  logic [7:0] exp_dat;
  bit         exp_known;

  initial begin
    vec_t v;
    logic [7:0] e_wa, e_wd, e_ra;
    bit ok;

    //           rst wq     wa0    wa1    wd0    wd1    rq     ra0    ra1    wg     rg     rv   chk e_d
    vecs[0]  = mk(1, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b11, 8'h50, 8'h60, 2'b00, 2'b00, 2'b00, 0, 8'h00);
    vecs[1]  = mk(1, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b11, 8'h50, 8'h60, 2'b00, 2'b00, 2'b00, 0, 8'h00);
    vecs[2]  = mk(0, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b11, 8'h50, 8'h60, 2'b01, 2'b01, 2'b00, 0, 8'h00);
    vecs[3]  = mk(0, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b11, 8'h50, 8'h60, 2'b10, 2'b10, 2'b01, 0, 8'h00);
    vecs[4]  = mk(0, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b10, 0, 8'h00);
    vecs[5]  = mk(0, 2'b11, 8'h10, 8'h20, 8'h11, 8'h22, 2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 2'b00, 0, 8'h00);
    vecs[6]  = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 8'h10, 8'h20, 2'b00, 2'b01, 2'b00, 0, 8'h00);
    vecs[7]  = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 8'h10, 8'h20, 2'b00, 2'b10, 2'b01, 1, 8'h11);
    vecs[8]  = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 1, 8'h22);
    vecs[9]  = mk(0, 2'b01, 8'h33, 8'h00, 8'hA5, 8'h00, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 0, 8'h00);
    vecs[10] = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'h33, 8'h00, 2'b00, 2'b01, 2'b00, 0, 8'h00);
    vecs[11] = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 1, 8'hA5);
    vecs[12] = mk(0, 2'b01, 8'h40, 8'h00, 8'h5A, 8'h00, 2'b10, 8'h00, 8'h40, 2'b01, 2'b00, 2'b00, 0, 8'h00);
    vecs[13] = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 8'h00, 8'h40, 2'b00, 2'b10, 2'b00, 0, 8'h00);
    vecs[14] = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 1, 8'h5A);
    vecs[15] = mk(0, 2'b01, 8'h70, 8'h00, 8'h77, 8'h00, 2'b01, 8'h33, 8'h00, 2'b01, 2'b01, 2'b00, 0, 8'h00);
    vecs[16] = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 1, 8'hA5);
    vecs[17] = mk(0, 2'b01, 8'h80, 8'h00, 8'h88, 8'h00, 2'b01, 8'h70, 8'h00, 2'b01, 2'b01, 2'b00, 0, 8'h00);
    vecs[18] = mk(1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 0, 8'h00);
    vecs[19] = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 0, 8'h00);
    vecs[20] = mk(0, 2'b11, 8'h90, 8'hA0, 8'h99, 8'hAA, 2'b11, 8'h10, 8'h20, 2'b01, 2'b01, 2'b00, 0, 8'h00);
    vecs[21] = mk(0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 1, 8'h11);

    rst = 1'b1; wr_req = '0; wr_addr = '0; wr_data = '0; rd_req = '0; rd_addr = '0;

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      @(negedge clk);
      rst     = v.rst;
      wr_req  = v.wr_req;
      wr_addr = {v.wa1, v.wa0};
      wr_data = {v.wd1, v.wd0};
      rd_req  = v.rd_req;
      rd_addr = {v.ra1, v.ra0};
      #1;
      e_wa = v.e_wg[0] ? v.wa0 : (v.e_wg[1] ? v.wa1 : 8'h00);
      e_wd = v.e_wg[0] ? v.wd0 : (v.e_wg[1] ? v.wd1 : 8'h00);
      e_ra = v.e_rg[0] ? v.ra0 : (v.e_rg[1] ? v.ra1 : 8'h00);
      check($sformatf("row%0d wr_gnt", k), 32'(wr_gnt), 32'(v.e_wg));
      check($sformatf("row%0d rd_gnt", k), 32'(rd_gnt), 32'(v.e_rg));
      check($sformatf("row%0d rd_rvalid", k), 32'(rd_rvalid), 32'(v.e_rv));
      check($sformatf("row%0d ram_wr_en", k), 32'(ram_wr_en), 32'(|v.e_wg));
      check($sformatf("row%0d ram_wr_addr", k), 32'(ram_wr_addr), 32'(e_wa));
      check($sformatf("row%0d ram_data_in", k), 32'(ram_data_in), 32'(e_wd));
      check($sformatf("row%0d ram_rd_en", k), 32'(ram_rd_en), 32'(|v.e_rg));
      check($sformatf("row%0d ram_rd_addr", k), 32'(ram_rd_addr), 32'(e_ra));
      if (v.chk_d) check($sformatf("row%0d rd_rdata", k), 32'(rd_rdata), 32'(v.e_d));
    end

    // Random soak: requesters hold until granted, narrow address range to provoke hazards.
    for (int i = 0; i < 2; i++) begin
      wr_pend[i] = 0; rd_pend[i] = 0; wr_wait[i] = 0; rd_wait[i] = 0;
      wr_a[i] = '0; wr_d[i] = '0; rd_a[i] = '0;
    end
    for (int a = 0; a < 256; a++) begin
      known[a] = 0; ref_mem[a] = '0;
    end
    exp_rv = '0; exp_dat = '0; exp_known = 0;

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      check("soak rd_rvalid", 32'(rd_rvalid), 32'(exp_rv));
      if (exp_rv != 2'b00 && exp_known) check("soak rd_rdata", 32'(rd_rdata), 32'(exp_dat));

      for (int i = 0; i < 2; i++) begin
        if (!wr_pend[i] && ($urandom_range(1, 0) == 1)) begin
          wr_pend[i] = 1; wr_wait[i] = 0;
          wr_a[i] = 8'hC0 | 8'($urandom_range(3, 0));
          wr_d[i] = 8'($urandom);
        end
        if (!rd_pend[i] && ($urandom_range(1, 0) == 1)) begin
          rd_pend[i] = 1; rd_wait[i] = 0;
          rd_a[i] = 8'hC0 | 8'($urandom_range(3, 0));
        end
      end
      rst     = 1'b0;
      wr_req  = {wr_pend[1], wr_pend[0]};
      wr_addr = {wr_a[1], wr_a[0]};
      wr_data = {wr_d[1], wr_d[0]};
      rd_req  = {rd_pend[1], rd_pend[0]};
      rd_addr = {rd_a[1], rd_a[0]};
      #1;

      ok = ((wr_gnt & ~wr_req) == 2'b00) && $onehot0(wr_gnt) && ((wr_req == 2'b00) || (wr_gnt != 2'b00));
      check("soak wr_gnt legal", 32'(ok), 32'd1);
      ok = ((rd_gnt & ~rd_req) == 2'b00) && $onehot0(rd_gnt);
      check("soak rd_gnt legal", 32'(ok), 32'd1);
      // A read may only be withheld when some requested read address equals the write address.
      ok = 1;
      if (rd_req != 2'b00 && rd_gnt == 2'b00) begin
        ok = (wr_gnt != 2'b00) &&
             ((rd_pend[0] && rd_a[0] == ram_wr_addr) || (rd_pend[1] && rd_a[1] == ram_wr_addr));
      end
      check("soak read deferral justified", 32'(ok), 32'd1);
      ok = !((rd_gnt != 2'b00) && (wr_gnt != 2'b00) && (ram_rd_addr == ram_wr_addr));
      check("soak hazard missed", 32'(ok), 32'd1);

      exp_rv = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (rd_gnt[i]) begin
          check("soak rd wait", 32'(rd_wait[i] <= NR - 1), 32'd1);
          exp_rv[i] = 1'b1;
          exp_dat   = ref_mem[rd_a[i]];
          exp_known = known[rd_a[i]];
          rd_pend[i] = 0;
        end else if (rd_pend[i] && rd_gnt != 2'b00) begin
          rd_wait[i]++;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (wr_gnt[i]) begin
          check("soak wr wait", 32'(wr_wait[i] <= NR - 1), 32'd1);
          ref_mem[wr_a[i]] = wr_d[i];
          known[wr_a[i]]   = 1;
          wr_pend[i] = 0;
        end else if (wr_pend[i]) begin
          wr_wait[i]++;
        end
      end
    end

    @(negedge clk);
    wr_req = '0; rd_req = '0;
    check("soak final rd_rvalid", 32'(rd_rvalid), 32'(exp_rv));
    if (exp_rv != 2'b00 && exp_known) check("soak final rd_rdata", 32'(rd_rdata), 32'(exp_dat));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
